dma_burst_addr_gen: RTL

Parametrised burst address generator for the DMA datapath, the successor to the single-shot source/destination address generator. One start command latches a source and destination base, a beat count, a stride and a per-channel addressing mode. The block then issues one source/destination address pair per beat over a valid/ready handshake to the transfer engine. It sits between the DMA register/command front end and the read/write beat engine.

---
 rtl/dma_addr_pkg.sv | 19 +
 rtl/dma_addr_step.sv | 39 +++
 rtl/dma_burst_addr_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_addr_pkg.sv
// dma_addr_pkg
//   Shared types for the DMA burst address generator:
//   - addr_mode_e : per-channel address stepping mode (value 3 is reserved)
//   - state_e     : burst FSM state encoding
package dma_addr_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_WRAP  = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dma_addr_step.sv
// dma_addr_step
//   Combinational next-address calculation for one DMA channel.
//   Ports:
//     addr_i   : current address
//     stride_i : unsigned per-beat increment
//     mode_i   : addr_mode_e encoding (3 is reserved and holds like FIXED)
//     addr_o   : address for the following beat
module dma_addr_step
  import dma_addr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int STRIDE_WIDTH = 8,
  parameter int WRAP_LOG2    = 6
) (
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [STRIDE_WIDTH-1:0] stride_i,
  input  logic [1:0]              mode_i,
  output logic [ADDR_WIDTH-1:0]   addr_o
);

  logic [ADDR_WIDTH-1:0] incr_addr_s;
  logic [WRAP_LOG2-1:0]  wrap_low_s;

  // Both candidate results; the sums truncate, which gives the modulo wrap for free.
  assign incr_addr_s = addr_i + ADDR_WIDTH'(stride_i);
  assign wrap_low_s  = addr_i[WRAP_LOG2-1:0] + WRAP_LOG2'(stride_i);

  // Select the next address according to the channel mode.
  always_comb begin
    addr_o = addr_i;
    case (mode_i)
      MODE_INCR:  addr_o = incr_addr_s;
      MODE_FIXED: addr_o = addr_i;
      MODE_WRAP:  addr_o = {addr_i[ADDR_WIDTH-1:WRAP_LOG2], wrap_low_s};
      default:    addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/dma_burst_addr_gen.sv
// dma_burst_addr_gen
//   Burst address generator: a start command latches source/destination
//   bases, beat count, stride and per-channel modes, then one address pair
//   per beat is offered on a valid/ready stream.
//   Ports:
//     clk_i, resetn_i           : clock, asynchronous active-low reset
//     start_i .. dst_mode_i     : command inputs, sampled only in IDLE
//     abort_i                   : ends an active burst early
//     addr_valid_o/addr_ready_i : address stream handshake
//     src_addr_o, dst_addr_o    : current address pair
//     beat_idx_o, last_o        : beat index and final-beat flag
//     busy_o, done_o, aborted_o : status (done_o is a one-cycle pulse)
module dma_burst_addr_gen
  import dma_addr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int STRIDE_WIDTH = 8,
  parameter int WRAP_LOG2    = 6
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic [STRIDE_WIDTH-1:0] stride_i,
  input  logic [1:0]              src_mode_i,
  input  logic [1:0]              dst_mode_i,
  input  logic                    abort_i,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic [ADDR_WIDTH-1:0]   src_addr_o,
  output logic [ADDR_WIDTH-1:0]   dst_addr_o,
  output logic [LEN_WIDTH-1:0]    beat_idx_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o
);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [1:0]              src_mode_q, src_mode_d;
  logic [1:0]              dst_mode_q, dst_mode_d;
  logic [ADDR_WIDTH-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic [LEN_WIDTH-1:0]    beat_idx_q, beat_idx_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic [ADDR_WIDTH-1:0]   src_next_s;
  logic [ADDR_WIDTH-1:0]   dst_next_s;
  logic [LEN_WIDTH-1:0]    idx_next_s;
  logic                    hs_s;

  dma_addr_step #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH),
    .WRAP_LOG2   (WRAP_LOG2)
  ) u_src_step (
    .addr_i  (src_addr_q),
    .stride_i(stride_q),
    .mode_i  (src_mode_q),
    .addr_o  (src_next_s)
  );

  dma_addr_step #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH),
    .WRAP_LOG2   (WRAP_LOG2)
  ) u_dst_step (
    .addr_i  (dst_addr_q),
    .stride_i(stride_q),
    .mode_i  (dst_mode_q),
    .addr_o  (dst_next_s)
  );

  assign hs_s       = valid_q & addr_ready_i;
  assign idx_next_s = beat_idx_q + LEN_WIDTH'(1);

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    stride_d   = stride_q;
    src_mode_d = src_mode_q;
    dst_mode_d = dst_mode_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    beat_idx_d = beat_idx_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = aborted_q;

    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        aborted_d = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        if (start_i) begin
          len_d      = len_i;
          stride_d   = stride_i;
          src_mode_d = src_mode_i;
          dst_mode_d = dst_mode_i;
          src_addr_d = src_addr_i;
          dst_addr_d = dst_addr_i;
          beat_idx_d = {LEN_WIDTH{1'b0}};
          busy_d     = 1'b1;
          if (len_i != {LEN_WIDTH{1'b0}}) begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            last_d  = (len_i == LEN_WIDTH'(1));
          end else begin
            // Empty command: straight to completion, no beats offered.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (hs_s) begin
          beat_idx_d = idx_next_s;
          src_addr_d = src_next_s;
          dst_addr_d = dst_next_s;
          last_d     = (idx_next_s == (len_q - LEN_WIDTH'(1)));
        end else begin
          beat_idx_d = beat_idx_q;
        end
        // An abort wins even when it lands on the final handshake.
        if ((hs_s && last_q) || abort_i) begin
          state_d   = ST_DONE;
          valid_d   = 1'b0;
          last_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = abort_i;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        aborted_d = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        aborted_d = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
      end
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      len_q      <= {LEN_WIDTH{1'b0}};
      stride_q   <= {STRIDE_WIDTH{1'b0}};
      src_mode_q <= 2'd0;
      dst_mode_q <= 2'd0;
      src_addr_q <= {ADDR_WIDTH{1'b0}};
      dst_addr_q <= {ADDR_WIDTH{1'b0}};
      beat_idx_q <= {LEN_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      stride_q   <= stride_d;
      src_mode_q <= src_mode_d;
      dst_mode_q <= dst_mode_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      beat_idx_q <= beat_idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign addr_valid_o = valid_q;
  assign src_addr_o   = src_addr_q;
  assign dst_addr_o   = dst_addr_q;
  assign beat_idx_o   = beat_idx_q;
  assign last_o       = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;

endmodule
